// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit frame controller: start, LSB-first data, optional parity, stop
// Sequences the external serializer with load/shift enables; one line bit per i_clk cycle.
module uart_tx_ctrl #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_data_valid,
   input  logic                  i_par_en,
   input  logic                  i_par_type,
   input  logic                  i_ser_data,
   output logic                  o_ser_load,
   output logic                  o_ser_shift,
   output logic                  o_tx,
   output logic                  o_busy
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] bit_cnt;
   logic             data_par_q;
   logic             par_en_q;
   logic             par_type_q;
   logic             par_bit;

   // Raw data parity is latched at accept; odd parity is the inversion of it.
   assign par_bit = data_par_q ^ par_type_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         data_par_q <= 1'b0;
         par_en_q   <= 1'b0;
         par_type_q <= 1'b0;
         o_ser_load <= 1'b0;
      end else begin
         o_ser_load <= 1'b0;
         case (state)
            IDLE, STOP: begin
               if (i_data_valid) begin
                  data_par_q <= ^i_data;
                  par_en_q   <= i_par_en;
                  par_type_q <= i_par_type;
                  o_ser_load <= 1'b1;
                  state      <= START;
               end else begin
                  state      <= IDLE;
               end
            end
            START: begin
               bit_cnt <= '0;
               state   <= DATA;
            end
            DATA: begin
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  state <= par_en_q ? PARITY : STOP;
               end
            end
            PARITY: begin
               state <= STOP;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      o_tx = 1'b1;
      case (state)
         START:   o_tx = 1'b0;
         DATA:    o_tx = i_ser_data;
         PARITY:  o_tx = par_bit;
         default: o_tx = 1'b1;
      endcase
   end

   assign o_busy      = (state != IDLE);
   assign o_ser_shift = (state == DATA);

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Frame controller for the UART transmit path. It accepts a parallel byte through a valid strobe and sequences the TX serializer with load and shift enables. It builds the line frame around the serializer's bit output: start bit, LSB-first data bits, an optional even/odd parity bit and a stop bit. One line bit is sent per i_clk cycle, so i_clk is the baud-rate clock.

## Interface
- DATA_WIDTH, 8, data bits per frame; the serializer uses the same value.
- i_clk  input  1  baud-rate clock, rising-edge active.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_data  input  DATA_WIDTH  frame payload; parity is computed from it at accept.
- i_data_valid  input  1  request to send i_data; sampled only in IDLE and STOP.
- i_par_en  input  1  1 = insert parity bit; latched at accept.
- i_par_type  input  1  0 = even, 1 = odd; latched at accept.
- i_ser_data  input  1  current LSB from the TX serializer.
- o_ser_load  output  1  serializer load enable; registered, 1-cycle pulse.
- o_ser_shift  output  1  serializer shift enable.
- o_tx  output  1  UART line; idles high.
- o_busy  output  1  frame in progress.

## Operation
- FSM states are IDLE, START, DATA, PARITY and STOP. Encoding is free, but the state register is explicit.
- IDLE:
  - With i_data_valid=1, the block accepts the byte: it latches par_bit, par_en_q and par_type_q, sets o_ser_load for the next cycle, and moves to START.
  - Otherwise it stays in IDLE.
- START:
  - Lasts 1 cycle with o_tx=0 and o_ser_load=1; the serializer captures i_data here.
  - Then moves to DATA with bit_cnt=0.
- DATA:
  - Lasts DATA_WIDTH cycles with o_tx=i_ser_data and o_ser_shift=1.
  - bit_cnt increments each cycle; its width is $clog2(DATA_WIDTH), minimum 1.
  - At bit_cnt=DATA_WIDTH-1 the block moves to PARITY if par_en_q=1, else to STOP. The last shift is harmless.
- PARITY: lasts 1 cycle with o_tx=par_bit, then moves to STOP.
- Parity: even gives par_bit = ^i_data; odd gives par_bit = ~^i_data. Both are evaluated on i_data at accept.
- STOP: lasts 1 cycle with o_tx=1.
  - With i_data_valid=1, the block accepts the next byte as in IDLE and goes straight to START, with no idle gap.
  - Otherwise it goes to IDLE.
- i_data_valid is ignored in START, DATA and PARITY; the source must hold its request.
- o_tx is a combinational mux on the state register (and on i_ser_data in DATA only): IDLE gives 1, START gives 0, DATA gives i_ser_data, PARITY gives par_bit, STOP gives 1.
- o_busy is 1 in START, DATA, PARITY and STOP.
- o_ser_shift is 1 exactly when state=DATA.
- o_ser_load is a flop set on accept and cleared the next cycle. It is never high in two consecutive cycles.

## Timing
- Reset values (async, immediate, including mid-frame): state=IDLE, bit_cnt=0, par_bit=0, par_en_q=0, par_type_q=0, o_tx=1, o_busy=0, o_ser_load=0, o_ser_shift=0.
- Any partially sent frame is dropped; there is no resume after reset release.
- Latency: an accept at edge k puts START (o_tx=0) in cycle k+1, and the first data bit on the line in cycle k+2.
- Frame length is 2+DATA_WIDTH+par_en cycles: 10 for 8N1, 11 for 8E1/8O1.
- o_busy is high for exactly the frame length for an isolated frame.
- Back-to-back: with valid held, the STOP of frame n is immediately followed by the START of frame n+1, so o_busy stays high continuously.
- i_par_en and i_par_type changing mid-frame have no effect on the current frame.
- i_data changing after accept has no effect: the serializer holds the data and par_bit is latched.

## Test plan
- Reset, then idle for 5 cycles -> o_tx=1, o_busy=0, o_ser_load=0, o_ser_shift=0 throughout.
- i_data=0xA5, par_en=1, par_type=0, 1-cycle valid pulse -> o_tx sequence 0,1,0,1,0,0,1,0,1,0,1 and o_busy high for 11 cycles.
  - o_ser_load is high only in the START cycle; o_ser_shift is high for 8 cycles.
- i_data=0x03, par_en=1, par_type=1 -> parity bit 1. Then i_data=0x03, par_en=0 -> 10-cycle frame 0,1,1,0,0,0,0,0,0,1 with no parity bit.
- Valid held high with 0x55 then 0xF0 (8N1) -> second START directly follows the first STOP, o_busy high for 20 cycles, and o_tx is never high between the frames.
- Valid pulsed with 0xFF in the 3rd DATA cycle of an active frame -> ignored; the current frame completes unchanged and returns to IDLE.
- i_rst_n asserted in the 4th DATA cycle of 0x00 -> o_tx=1 and o_busy=0 immediately.
  - After release, a new valid with 0x81 sends a clean complete frame.
